// File: rtl/rank_filter_3x3.sv
// rank_filter_3x3: causal 3x3 rank-order filter (median / min / max / bypass)
// on a single-channel pixel stream, with its own two-line buffer.
// Build option: define RANK_FILTER_BORDER_ZERO_EN to force oData=0 for pixels
// whose window is incomplete (first two columns of a line, first two lines of
// a frame). Without it, border pixels carry whatever the window holds.
// Pixel-in to pixel-out latency is LATENCY (4) clocks in both builds.
module rank_filter_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_de,
  input  logic                  i_hs,
  input  logic                  i_vs,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic [1:0]            mode,
  output logic                  o_de,
  output logic                  o_hs,
  output logic                  o_vs,
  output logic [DATA_WIDTH-1:0] oData
);

  typedef logic [DATA_WIDTH-1:0] pix_t;
  typedef struct packed { pix_t hi; pix_t md; pix_t lo; } srt_t;
  typedef enum logic [1:0] {MD_MEDIAN, MD_MIN, MD_MAX, MD_BYPASS} mode_t;

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic srt_t sort3(input pix_t a, input pix_t b, input pix_t c);
    srt_t s;
    s.hi = max2(max2(a, b), c);
    s.lo = min2(min2(a, b), c);
    s.md = max2(min2(a, b), min2(max2(a, b), c));
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Column tracking, frame-start detection, mode capture
  // ---------------------------------------------------------------------------
  logic                  de_q, vs_q, full;
  logic [ADDR_WIDTH-1:0] col;
  mode_t                 mode_r;
  logic                  de_fall, vs_rise, we;

  assign de_fall = de_q & ~i_de;
  assign vs_rise = i_vs & ~vs_q;
  // Once the last column is written the line is full; extra pixels are dropped.
  assign we      = i_de & ~full;

  // Column counter saturates at the last column; mode latches at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q   <= 1'b0;
      vs_q   <= 1'b0;
      col    <= '0;
      full   <= 1'b0;
      mode_r <= MD_MEDIAN;
    end else begin
      de_q <= i_de;
      vs_q <= i_vs;
      if (vs_rise) mode_r <= mode_t'(mode);
      if (i_de) begin
        if (col == ADDR_WIDTH'(IMG_WIDTH - 1)) full <= 1'b1;
        else                                   col  <= col + 1'b1;
      end else if (de_fall) begin
        col  <= '0;
        full <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: lb0 holds the previous line, lb1 the one before it
  // ---------------------------------------------------------------------------
  pix_t lb0 [IMG_WIDTH];
  pix_t lb1 [IMG_WIDTH];
  pix_t lb0_rd, lb1_rd;

  assign lb0_rd = lb0[col];
  assign lb1_rd = lb1[col];

  // Read-before-write: lb0's old content cascades into lb1 at the same column.
  always_ff @(posedge clk) begin
    if (we) begin
      lb0[col] <= iData;
      lb1[col] <= lb0_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // S0: window shift registers. Row 2 is the current line, [0] the newest column.
  // ---------------------------------------------------------------------------
  logic [2:0][2:0][DATA_WIDTH-1:0] win;

  // Window advances only on active pixels; it holds during blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (i_de) begin
      win[2] <= {win[2][1:0], iData};
      win[1] <= {win[1][1:0], lb0_rd};
      win[0] <= {win[0][1:0], lb1_rd};
    end
  end

`ifdef RANK_FILTER_BORDER_ZERO_EN
  localparam int STAGES = 2;
  logic [1:0]      row;
  logic            armed;
  logic [STAGES:0] vld_pipe;

  // Row counter only runs after a frame start has been seen, so a reset
  // mid-frame keeps the output masked until the next i_vs rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row   <= '0;
      armed <= 1'b0;
    end else if (vs_rise) begin
      row   <= '0;
      armed <= 1'b1;
    end else if (de_fall && armed && row != 2'd2) begin
      row <= row + 1'b1;
    end
  end

  // Window-complete flag travels alongside the data; S0 entry moves with win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (i_de) vld_pipe[0] <= (col >= ADDR_WIDTH'(2)) && (row == 2'd2);
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // S1..S3: row sort, column merge, final select
  // ---------------------------------------------------------------------------
  srt_t [2:0]              srt;
  pix_t                    cur1, t0, t1, t2;
  mode_t                   m2;
  logic [LATENCY-1:0][2:0] syn;
  pix_t                    result;
  logic                    keep;

  assign result = (m2 == MD_MEDIAN) ? sort3(t0, t1, t2).md : t0;

`ifdef RANK_FILTER_BORDER_ZERO_EN
  assign keep = syn[LATENCY-2][2] & vld_pipe[STAGES];
`else
  assign keep = syn[LATENCY-2][2];
`endif

  // Rank pipeline runs every clock so in-flight pixels drain after i_de drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srt   <= '0;
      cur1  <= '0;
      t0    <= '0;
      t1    <= '0;
      t2    <= '0;
      m2    <= MD_MEDIAN;
      oData <= '0;
    end else begin
      for (int r = 0; r < 3; r++) srt[r] <= sort3(win[r][0], win[r][1], win[r][2]);
      cur1 <= win[2][0];
      m2   <= mode_r;
      t1   <= '0;
      t2   <= '0;
      unique case (mode_r)
        MD_MEDIAN: begin
          t0 <= sort3(srt[0].hi, srt[1].hi, srt[2].hi).lo;
          t1 <= sort3(srt[0].md, srt[1].md, srt[2].md).md;
          t2 <= sort3(srt[0].lo, srt[1].lo, srt[2].lo).hi;
        end
        MD_MIN:    t0 <= sort3(srt[0].lo, srt[1].lo, srt[2].lo).lo;
        MD_MAX:    t0 <= sort3(srt[0].hi, srt[1].hi, srt[2].hi).hi;
        default:   t0 <= cur1;
      endcase
      oData <= keep ? result : '0;
    end
  end

  // Sync strobes delayed to match the data path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) syn <= '0;
    else        syn <= {syn[LATENCY-2:0], {i_de, i_hs, i_vs}};
  end

  assign o_de = syn[LATENCY-1][2];
  assign o_hs = syn[LATENCY-1][1];
  assign o_vs = syn[LATENCY-1][0];

endmodule

// File: tb/tb_rank_filter_3x3.sv
// Directed bench for rank_filter_3x3 on an 8-pixel-wide image.
module tb_rank_filter_3x3;
  localparam int DW = 8;
  localparam int IW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_de = 1'b0, i_hs = 1'b0, i_vs = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] iData = '0;
  logic          o_de, o_hs, o_vs;
  logic [DW-1:0] oData;

  rank_filter_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .ADDR_WIDTH(AW), .LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs),
    .iData(iData), .mode(mode), .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs), .oData(oData)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output capture and strobe-delay check against the bench's own 4-deep history.
  logic [DW-1:0]  outq[$];
  logic [3:0][2:0] hist = '0;
  bit             lat_on = 1'b0;

  always @(posedge clk) hist <= {hist[2:0], {i_de, i_hs, i_vs}};

  always @(negedge clk) begin
    if (o_de) outq.push_back(oData);
    if (lat_on) begin
      chk("o_de_delay", o_de, hist[3][2]);
      chk("o_hs_delay", o_hs, hist[3][1]);
      chk("o_vs_delay", o_vs, hist[3][0]);
      if (!o_de) chk("odata_idle", oData, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0: flat 0x55; 1: flat 0x10 with 0xFF at (2,3); 2: ramp col+1
  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 8'h55;
      1:       return (r == 2 && c == 3) ? 8'hFF : 8'h10;
      default: return 8'(c + 1);
    endcase
  endfunction

  // Hand-derived results: 0 flat, 1 median/min of impulse, 2 max of impulse, 3 bypass ramp
  function automatic logic [7:0] expect_px(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'h55;
      1:       return 8'h10;
      2:       return (r >= 2 && r <= 4 && c >= 3 && c <= 5) ? 8'hFF : 8'h10;
      default: return 8'(c + 1);
    endcase
  endfunction

  task automatic send_frame(input int pat, input int nl, input logic [1:0] md, input logic [1:0] md_mid);
    outq.delete();
    i_vs = 1'b1; mode = md; tick(); tick();
    i_vs = 1'b0; tick(); tick();
    for (int r = 0; r < nl; r++) begin
      if (r == 1) mode = md_mid;
      i_hs = 1'b1; tick();
      i_hs = 1'b0; tick();
      for (int c = 0; c < IW; c++) begin
        i_de = 1'b1; iData = pix(pat, r, c); tick();
      end
      i_de = 1'b0; iData = '0; tick(); tick(); tick();
    end
    repeat (8) tick();
  endtask

  task automatic check_frame(input string name, input int nl, input int kind);
    bit border;
    chk({name, " count"}, outq.size(), nl * IW);
    for (int k = 0; k < outq.size() && k < nl * IW; k++) begin
      int r, c;
      r = k / IW;
      c = k % IW;
      border = (r < 2) || (c < 2);
`ifdef RANK_FILTER_BORDER_ZERO_EN
      chk($sformatf("%s r%0d c%0d", name, r, c), outq[k], border ? 8'h00 : expect_px(kind, r, c));
`else
      if (!border || kind == 3)
        chk($sformatf("%s r%0d c%0d", name, r, c), outq[k], expect_px(kind, r, c));
`endif
    end
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst o_de", o_de, 0);
    chk("rst oData", oData, 0);
    rst_n = 1'b1; tick();
    chk("post_rst o_vs", o_vs, 0);
    chk("post_rst oData", oData, 0);

    lat_on = 1'b1;
    send_frame(0, 4, 2'd0, 2'd0);
    lat_on = 1'b0;
    check_frame("flat_med", 4, 0);

    send_frame(1, 6, 2'd0, 2'd0);
    check_frame("imp_med", 6, 1);

    send_frame(1, 6, 2'd1, 2'd1);
    check_frame("imp_min", 6, 1);

    // mode moves to max mid-frame: this frame must stay median
    send_frame(1, 6, 2'd0, 2'd2);
    check_frame("midchg_med", 6, 1);

    send_frame(1, 6, 2'd2, 2'd2);
    check_frame("imp_max", 6, 2);

    // reset in the middle of an active line
    i_vs = 1'b1; tick(); i_vs = 1'b0; tick(); tick();
    for (int c = 0; c < 6; c++) begin
      i_de = 1'b1; iData = 8'h33; tick();
    end
    chk("pre_rst o_de", o_de, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid o_de", o_de, 0);
    chk("rst_mid o_hs", o_hs, 0);
    chk("rst_mid o_vs", o_vs, 0);
    chk("rst_mid oData", oData, 0);
    tick(); tick(); tick();
    rst_n = 1'b1; i_de = 1'b0; iData = '0;
    repeat (4) tick();
    send_frame(2, 6, 2'd3, 2'd3);
    check_frame("ramp_byp", 6, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
